// File: rtl/ws2812_feeder.sv
// WS2812 frame feeder: holds an RGB frame in a local RAM and streams brightness-scaled GRB
// words into one PIO TX FIFO, then idles for the latch gap before signalling done.
module ws2812_feeder #(
  parameter int unsigned NPIX         = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned LATCH_CYCLES = 1500,
  parameter int unsigned SM           = 0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [7:0]        brightness,
  input  logic              start,
  input  logic [3:0]        full,
  output logic [3:0]        action,
  output logic [31:0]       din,
  output logic [1:0]        mindex,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(LATCH_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StScale, StWait, StBubble, StLatch, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [7:0]        bright_q, bright_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       din_q, din_d;
  logic [3:0]        action_q, action_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [23:0]       rd_q;
  logic [8:0]        mult;
  logic              wr_ok;
  logic              unused_full;

  logic [23:0] mem [NPIX];

  // Drop writes beyond the frame when the address space is larger than NPIX.
  if (NPIX < (1 << ADDR_W)) begin : g_wr_guard
    assign wr_ok = wr_en && (wr_addr < ADDR_W'(NPIX));
  end else begin : g_wr_all
    assign wr_ok = wr_en;
  end

  // Read-before-write: a same-cycle write to the fetched pixel is not seen by that fetch.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (state_q == StFetch) begin
      rd_q <= mem[pix_q];
    end
  end

  assign mult = {1'b0, bright_q} + 9'd1;

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] m);
    logic [15:0] p;
    p = 16'(c) * 16'(m);
    return p[15:8];
  endfunction

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    bright_d = bright_q;
    word_d   = word_q;
    din_d    = din_q;
    action_d = 4'd0;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bright_d = brightness;
          pix_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: state_d = StScale;
      StScale: begin
        word_d  = {scale_ch(rd_q[15:8], mult), scale_ch(rd_q[23:16], mult),
                   scale_ch(rd_q[7:0], mult), 8'h00};
        state_d = StWait;
      end
      StWait: begin
        if (!full[SM]) begin
          action_d = 4'd4;
          din_d    = word_q;
          state_d  = StBubble;
        end
      end
      StBubble: begin
        if (pix_q == ADDR_W'(NPIX - 1)) begin
          cnt_d   = '0;
          state_d = StLatch;
        end else begin
          pix_d   = pix_q + 1'b1;
          state_d = StFetch;
        end
      end
      StLatch: begin
        if (cnt_q == CntW'(LATCH_CYCLES - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= StIdle;
      pix_q    <= '0;
      bright_q <= '0;
      word_q   <= '0;
      din_q    <= '0;
      action_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      bright_q <= bright_d;
      word_q   <= word_d;
      din_q    <= din_d;
      action_q <= action_d;
      cnt_q    <= cnt_d;
    end
  end

  assign unused_full = ^full;

  assign action = action_q;
  assign din    = din_q;
  assign mindex = 2'(SM);
  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign done   = (state_q == StDone);

endmodule
